// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for the shared MU0 memory: grants one master,
// holds the memory strobes for a fixed access time, then returns a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned FIXED_PRIO  = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic        i_m0_rnw,
  input  logic [11:0] i_m0_addr,
  input  logic [15:0] i_m0_wdata,
  output logic        o_m0_ack,
  output logic [15:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_rnw,
  input  logic [11:0] i_m1_addr,
  input  logic [15:0] i_m1_wdata,
  output logic        o_m1_ack,
  output logic [15:0] o_m1_rdata,
  output logic        o_mem_rq,
  output logic        o_mem_rnw,
  output logic [11:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_owner
);

  localparam logic [3:0] WsLoad = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      r_state, w_state_next;
  logic        r_owner;
  logic        r_rnw;
  logic [11:0] r_addr;
  logic [15:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [15:0] r_rdata;
  logic        r_keep;

  logic w_grant_valid;
  logic w_grant;
  logic w_owner_req;
  logic w_access;
  logic w_ack;

  always_comb begin
    w_grant_valid = i_m0_req | i_m1_req;
    w_grant       = i_m1_req;
    if (i_m0_req && i_m1_req) begin
      w_grant = (FIXED_PRIO != 0) ? 1'b0 : ~r_owner;
    end
    w_owner_req = r_owner ? i_m1_req : i_m0_req;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_grant_valid) w_state_next = StAccess;
      StAccess: if (r_cnt == 4'd0) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_owner <= 1'b1;
      r_rnw   <= 1'b0;
      r_addr  <= 12'd0;
      r_wdata <= 16'd0;
      r_cnt   <= 4'd0;
      r_rdata <= 16'd0;
      r_keep  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant_valid) begin
            r_owner <= w_grant;
            r_rnw   <= w_grant ? i_m1_rnw : i_m0_rnw;
            r_addr  <= w_grant ? i_m1_addr : i_m0_addr;
            r_wdata <= w_grant ? i_m1_wdata : i_m0_wdata;
            r_cnt   <= WsLoad;
            r_rdata <= 16'd0;
            r_keep  <= 1'b1;
          end
        end
        StAccess: begin
          // A master that lets go mid-access forfeits its ack; the access still completes.
          if (!w_owner_req) r_keep <= 1'b0;
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= r_rnw ? i_mem_rdata : 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_access    = (r_state == StAccess);
    w_ack       = (r_state == StDone) && r_keep;
    o_mem_rq    = w_access;
    o_mem_rnw   = w_access & r_rnw;
    o_mem_addr  = w_access ? r_addr : 12'd0;
    o_mem_wdata = (w_access && !r_rnw) ? r_wdata : 16'd0;
    o_m0_ack    = w_ack & ~r_owner;
    o_m1_ack    = w_ack & r_owner;
    o_m0_rdata  = o_m0_ack ? r_rdata : 16'd0;
    o_m1_rdata  = o_m1_ack ? r_rdata : 16'd0;
    o_busy      = (r_state != StIdle);
    o_owner     = r_owner;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance
// share the same master stimulus, each with its own simple memory model.
module tb_mem_arbiter;

  typedef struct packed {
    logic        mem_rq;
    logic        mem_rnw;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        m0_ack;
    logic [15:0] m0_rdata;
    logic        m1_ack;
    logic [15:0] m1_rdata;
    logic        busy;
    logic        owner;
  } outs_t;

  typedef struct {
    logic  m0_req;
    logic  m1_req;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req, m0_rnw, m1_req, m1_rnw;
  logic [11:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic [15:0] rd0, rd1;
  outs_t       o0, o1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [11:0] a);
    return (a == 12'h123) ? 16'hBEEF : {4'hD, a};
  endfunction

  assign rd0 = mem_f(o0.mem_addr);
  assign rd1 = mem_f(o1.mem_addr);

  mem_arbiter #(.WAIT_STATES(1), .FIXED_PRIO(0)) dut0 (
    .i_clk(clk), .i_reset(reset),
    .i_m0_req(m0_req), .i_m0_rnw(m0_rnw), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_ack(o0.m0_ack), .o_m0_rdata(o0.m0_rdata),
    .i_m1_req(m1_req), .i_m1_rnw(m1_rnw), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_ack(o0.m1_ack), .o_m1_rdata(o0.m1_rdata),
    .o_mem_rq(o0.mem_rq), .o_mem_rnw(o0.mem_rnw), .o_mem_addr(o0.mem_addr),
    .o_mem_wdata(o0.mem_wdata), .i_mem_rdata(rd0),
    .o_busy(o0.busy), .o_owner(o0.owner)
  );

  mem_arbiter #(.WAIT_STATES(1), .FIXED_PRIO(1)) dut1 (
    .i_clk(clk), .i_reset(reset),
    .i_m0_req(m0_req), .i_m0_rnw(m0_rnw), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_ack(o1.m0_ack), .o_m0_rdata(o1.m0_rdata),
    .i_m1_req(m1_req), .i_m1_rnw(m1_rnw), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_ack(o1.m1_ack), .o_m1_rdata(o1.m1_rdata),
    .o_mem_rq(o1.mem_rq), .o_mem_rnw(o1.mem_rnw), .o_mem_addr(o1.mem_addr),
    .o_mem_wdata(o1.mem_wdata), .i_mem_rdata(rd1),
    .o_busy(o1.busy), .o_owner(o1.owner)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic outs_t mk(input logic rq, input logic rnw, input logic [11:0] a,
                               input logic [15:0] wd, input logic a0, input logic [15:0] r0,
                               input logic a1, input logic [15:0] r1, input logic bsy,
                               input logic own);
    outs_t o;
    o = '{mem_rq: rq, mem_rnw: rnw, mem_addr: a, mem_wdata: wd, m0_ack: a0, m0_rdata: r0,
          m1_ack: a1, m1_rdata: r1, busy: bsy, owner: own};
    return o;
  endfunction

  // Acks to both masters at once is never legal.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((o0.m0_ack && o0.m1_ack) || (o1.m0_ack && o1.m1_ack)) begin
        errors++;
        $display("FAIL dual_ack: dut0 %b%b dut1 %b%b required no overlap",
                 o0.m0_ack, o0.m1_ack, o1.m0_ack, o1.m1_ack);
      end
    end
  end

  initial begin
    vec_t  vecs[8];
    outs_t rst_exp;
    int    q0[$];
    int    q1[$];
    int    lat0, lat1;

    m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 12'h123; m0_wdata = 16'h1111;
    m1_req = 1'b1; m1_rnw = 1'b0; m1_addr = 12'h0FF; m1_wdata = 16'h5A5A;

    // Reset held with both requests high.
    #17;
    rst_exp = mk(0, 0, 12'h0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 1);
    chk("reset_dut0", 80'(o0), 80'(rst_exp));
    chk("reset_dut1", 80'(o1), 80'(rst_exp));
    #5 reset = 1'b1;

    // m0 read (0x123 -> 0xBEEF) then m1 write (0x0FF <- 0x5A5A); same result on both.
    vecs[0] = '{1, 1, mk(1, 1, 12'h123, 16'h0, 0, 16'h0, 0, 16'h0, 1, 0)};
    vecs[1] = '{1, 1, mk(1, 1, 12'h123, 16'h0, 0, 16'h0, 0, 16'h0, 1, 0)};
    vecs[2] = '{1, 1, mk(0, 0, 12'h0, 16'h0, 1, 16'hBEEF, 0, 16'h0, 1, 0)};
    vecs[3] = '{0, 1, mk(0, 0, 12'h0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0)};
    vecs[4] = '{0, 1, mk(1, 0, 12'h0FF, 16'h5A5A, 0, 16'h0, 0, 16'h0, 1, 1)};
    vecs[5] = '{0, 1, mk(1, 0, 12'h0FF, 16'h5A5A, 0, 16'h0, 0, 16'h0, 1, 1)};
    vecs[6] = '{0, 1, mk(0, 0, 12'h0, 16'h0, 0, 16'h0, 1, 16'h0, 1, 1)};
    vecs[7] = '{0, 0, mk(0, 0, 12'h0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 1)};
    for (int i = 0; i < 8; i++) begin
      m0_req = vecs[i].m0_req;
      m1_req = vecs[i].m1_req;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_dut0", i), 80'(o0), 80'(vecs[i].exp));
      chk($sformatf("vec%0d_dut1", i), 80'(o1), 80'(vecs[i].exp));
    end

    // Both masters request continuously.
    m0_rnw = 1'b1; m0_addr = 12'h010; m1_rnw = 1'b1; m1_addr = 12'h020;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 40 && (q0.size() < 4 || q1.size() < 4); c++) begin
      @(posedge clk); #1;
      if (o0.m0_ack) begin q0.push_back(0); chk("rr_m0_rdata", 80'(o0.m0_rdata), 80'h D010); end
      if (o0.m1_ack) begin q0.push_back(1); chk("rr_m1_rdata", 80'(o0.m1_rdata), 80'h D020); end
      if (o1.m0_ack) begin q1.push_back(0); chk("fp_m0_rdata", 80'(o1.m0_rdata), 80'h D010); end
      if (o1.m1_ack) q1.push_back(1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_grant_count", 80'(q0.size()), 80'd4);
    chk("fp_grant_count", 80'(q1.size()), 80'd4);
    for (int i = 0; i < 4 && i < q0.size(); i++)
      chk($sformatf("rr_grant%0d", i), 80'(q0[i]), 80'(i % 2));
    for (int i = 0; i < 4 && i < q1.size(); i++)
      chk($sformatf("fp_grant%0d", i), 80'(q1[i]), 80'd0);
    repeat (2) @(posedge clk);
    #1;

    // Address change and request drop during the access.
    m0_rnw = 1'b1; m0_addr = 12'h100; m0_req = 1'b1;
    @(posedge clk); #1;
    chk("latch_addr_dut0", 80'(o0.mem_addr), 80'h100);
    m0_addr = 12'h200;
    @(posedge clk); #1;
    chk("held_addr_dut0", 80'({o0.mem_rq, o0.mem_addr}), 80'h1100);
    chk("held_addr_dut1", 80'({o1.mem_rq, o1.mem_addr}), 80'h1100);
    m0_req = 1'b0;
    @(posedge clk); #1;
    chk("drop_noack_dut0", 80'({o0.busy, o0.m0_ack, o0.m1_ack}), 80'b100);
    chk("drop_noack_dut1", 80'({o1.busy, o1.m0_ack, o1.m1_ack}), 80'b100);
    @(posedge clk); #1;
    chk("drop_idle_dut0", 80'(o0.busy), 80'd0);
    chk("drop_idle_dut1", 80'(o1.busy), 80'd0);

    // Reset during an access, then the same request runs to completion.
    m1_rnw = 1'b0; m1_addr = 12'h0AA; m1_wdata = 16'h1234; m1_req = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_rq", 80'({o0.mem_rq, o1.mem_rq}), 80'b11);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_dut0", 80'(o0), 80'(rst_exp));
    chk("async_reset_dut1", 80'(o1), 80'(rst_exp));
    #1 reset = 1'b1;
    lat0 = 0;
    lat1 = 0;
    for (int k = 1; k <= 10 && (lat0 == 0 || lat1 == 0); k++) begin
      @(posedge clk); #1;
      if (o0.mem_rq) chk("wr_wdata_dut0", 80'({o0.mem_rnw, o0.mem_wdata}), 80'h01234);
      if (o0.m1_ack && lat0 == 0) begin
        lat0 = k;
        chk("wr_rdata_dut0", 80'(o0.m1_rdata), 80'd0);
      end
      if (o1.m1_ack && lat1 == 0) lat1 = k;
    end
    m1_req = 1'b0;
    chk("post_reset_lat_dut0", 80'(lat0), 80'd3);
    chk("post_reset_lat_dut1", 80'(lat1), 80'd3);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
